seg_scan_ctrl: RTL and testbench

Time-multiplexed controller for a 4-digit common-anode 7-segment display. It drives the shared segment bus and scans one digit anode at a time.
- Each digit slot: a blanking (dead-time) gap, then a drive phase that decodes that digit's hex nibble.
- New values are double-buffered and committed only at frame boundaries, so a displayed frame never tears.
- Sits between the user datapath and the board's seg/an pins.

---
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Each digit slot is a BLANK gap of DEAD cycles followed
// by a DRIVE phase of CLK_DIV cycles; digits are scanned 0,1,2,3.
// New values are double-buffered (shadow -> shown) and committed only at a
// frame boundary or while the scan is off, so a frame never tears.
// Optional build macro SEG_LZB_EN enables leading-zero blanking on digits 3..1.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  localparam int CNT_MAX = (CLK_DIV > DEAD) ? CLK_DIV : DEAD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
  // frame_done is registered, so it is armed one cycle before DRIVE of
  // digit 3 ends in order to be high during that final DRIVE cycle.
  localparam logic [CW-1:0] DRIVE_PRE  = CW'(CLK_DIV - 2);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0]   shadow_data_q, shadow_data_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [15:0]   shown_data_q, shown_data_d;
  logic [3:0]    shown_dp_q, shown_dp_d;
  logic          pending_q, pending_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          commit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG_LZB_EN
  // A digit is a leading zero when it and every more-significant digit are 0.
  // Digit 0 always shows, so a value of zero still displays "0".
  function automatic logic lzb_blank(input logic [15:0] digits, input logic [1:0] idx);
    logic nonzero;
    nonzero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(idx)) && (digits[4*k +: 4] != 4'h0)) nonzero = 1'b1;
    end
    return (idx != 2'd0) && !nonzero;
  endfunction
`endif

  // Scan sequencing: OFF -> BLANK(DEAD) -> DRIVE(CLK_DIV) -> next digit; en=0 forces OFF.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
          frame_done_d = (idx_q == 2'd3) && (cnt_q == DRIVE_PRE);
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: load fills the shadow; commit copies the old shadow to shown.
  always_comb begin
    commit        = frame_done_q || (state_q == ST_OFF);
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    shown_data_d  = shown_data_q;
    shown_dp_d    = shown_dp_q;
    pending_d     = pending_q;
    if (commit) begin
      shown_data_d = shadow_data_q;
      shown_dp_d   = shadow_dp_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end
  end

  // Pin values follow the state being entered, so they change on the entry edge.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = hex_to_seg(shown_data_q[{idx_d, 2'b00} +: 4]);
      dp_d  = ~shown_dp_q[idx_d];
`ifdef SEG_LZB_EN
      if (lzb_blank(shown_data_q, idx_d)) seg_d = 7'h7F;
`endif
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shown_data_q  <= '0;
      shown_dp_q    <= '0;
      pending_q     <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shown_data_q  <= shown_data_d;
      shown_dp_q    <= shown_dp_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl (CLK_DIV=4, DEAD=2). The reference model tracks
// time since enable and derives slot/phase arithmetically from the frame
// layout; buffering is modelled as shadow/shown variables updated per edge.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int DEAD    = 2;
  localparam int SLOT    = CLK_DIV + DEAD;
  localparam int PERIOD  = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int checks = 0;
  int errors = 0;

  // Reference model state: m_t = cycles since scanning (re)started, -1 = off.
  int          m_t;
  logic [15:0] m_shown_d, m_shadow_d;
  logic [3:0]  m_shown_p, m_shadow_p;
  logic        m_pending;
  logic [6:0]  seg_tab [16];

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data_in(data_in),
    .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t        = -1;
    m_shown_d  = '0;
    m_shadow_d = '0;
    m_shown_p  = '0;
    m_shadow_p = '0;
    m_pending  = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic l, input logic [15:0] d, input logic [3:0] p);
    if ((m_t < 0) || ((m_t % PERIOD) == PERIOD - 1)) begin
      m_shown_d = m_shadow_d;
      m_shown_p = m_shadow_p;
      m_pending = 1'b0;
    end
    if (l) begin
      m_shadow_d = d;
      m_shadow_p = p;
      m_pending  = 1'b1;
    end
    if (!e) m_t = -1;
    else    m_t = m_t + 1;
  endtask

  task automatic check_outputs();
    logic [3:0] ea;
    logic [6:0] es;
    logic       edp, efd;
    int         pos, slot, nib;
    ea = 4'hF; es = 7'h7F; edp = 1'b1; efd = 1'b0;
    if (m_t >= 0) begin
      pos  = m_t % PERIOD;
      slot = pos / SLOT;
      if ((pos % SLOT) >= DEAD) begin
        ea  = ~(4'b0001 << slot);
        nib = int'(m_shown_d >> (4 * slot)) % 16;
        es  = seg_tab[nib];
`ifdef SEG_LZB_EN
        if ((slot > 0) && ((m_shown_d >> (4 * slot)) == 16'h0)) es = 7'h7F;
`endif
        edp = ~m_shown_p[slot];
      end
      efd = (pos == PERIOD - 1);
    end
    chk("an",         {12'h0, an},         {12'h0, ea});
    chk("seg",        {9'h0, seg},         {9'h0, es});
    chk("dp",         {15'h0, dp},         {15'h0, edp});
    chk("frame_done", {15'h0, frame_done}, {15'h0, efd});
    chk("pending",    {15'h0, pending},    {15'h0, m_pending});
  endtask

  task automatic step(input logic e, input logic l, input logic [15:0] d, input logic [3:0] p);
    en = e; load = l; data_in = d; dp_in = p;
    @(posedge clk);
    model_edge(e, l, d, p);
    #1;
    check_outputs();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic wait_frame_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      step(1'b1, 1'b0, 16'h0, 4'h0);
      if (frame_done === 1'b1) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL frame_done_wait observed=0 expected=1 t=%0t", $time);
    end
  endtask

  task automatic advance_to(input int target_pos);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
      if ((m_t >= 0) && ((m_t % PERIOD) == target_pos)) hit = 1'b1;
      else step(1'b1, 1'b0, 16'h0, 4'h0);
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL advance_pos observed=%0d expected=%0d t=%0t", m_t, target_pos, $time);
    end
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;

    // Reset held across edges
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Scan off, then enable with a first load; frame 0 shows zeros
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h1234, 4'b0010);
    run(2 * PERIOD + 5);

    // Asynchronous reset in the middle of a DRIVE phase
    advance_to(SLOT + DEAD + 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Decode sweep: one value per frame
    step(1'b1, 1'b0, 16'h0, 4'h0);
    for (int n = 0; n < 16; n++) begin
      logic [15:0] v;
      logic [3:0]  nn;
      nn = 4'(n);
      v  = {nn, nn, nn, nn};
      step(1'b1, 1'b1, v, nn);
      run(PERIOD - 1);
    end
    run(PERIOD);

    // Load landing on the commit edge: old shadow shows, new stays pending
    step(1'b1, 1'b1, 16'hAAAA, 4'h5);
    wait_frame_done();
    step(1'b1, 1'b1, 16'hBBBB, 4'hA);
    run(2 * PERIOD);

    // Drop enable mid digit-1 DRIVE; pending data commits while off
    wait_frame_done();
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b1, 1'b1, 16'h5A5A, 4'h9);
    advance_to(SLOT + DEAD + 1);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    run(PERIOD + 4);

    // Leading-zero patterns (blanked only when SEG_LZB_EN is defined)
    step(1'b1, 1'b1, 16'h0005, 4'h0);
    run(2 * PERIOD);
    step(1'b1, 1'b1, 16'h0000, 4'h1);
    run(2 * PERIOD);
    step(1'b1, 1'b1, 16'h0100, 4'h8);
    run(2 * PERIOD);

    // Randomized loads, data and occasional enable drops
    for (int i = 0; i < 1500; i++) begin
      logic        e, l;
      logic [15:0] d;
      logic [3:0]  p;
      e = ($urandom_range(0, 63) != 0);
      l = ($urandom_range(0, 9) == 0);
      d = 16'($urandom);
      p = 4'($urandom);
      step(e, l, d, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
